// File: rtl/fpa_arr_loader_if.sv
// Stream-in / adder-side bundle for fpa_arr_loader.
// The master modport is the loader; the slave modport is the upstream source and the adder.
interface fpa_arr_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9
);
    logic [DATA_WIDTH-1:0]        iS_DATA;
    logic                         iS_VALID;
    logic                         iS_LAST;
    logic [1:0]                   iS_OPERATION;
    logic                         oS_READY;
    logic [N:0][DATA_WIDTH-1:0]   oFPA_NUMBERS;
    logic [1:0]                   oFPA_OPERATION;
    logic                         oEN;
    logic [DATA_WIDTH-1:0]        iFPA_RESULT;
    logic [2:0]                   iFPA_FLAGS;
    logic                         iFPA_DATA_VALID;
    logic [DATA_WIDTH-1:0]        oRESULT;
    logic [2:0]                   oFLAGS;
    logic                         oRESULT_VALID;
    logic                         oTIMEOUT;

    modport master (
        input  iS_DATA, iS_VALID, iS_LAST, iS_OPERATION,
        input  iFPA_RESULT, iFPA_FLAGS, iFPA_DATA_VALID,
        output oS_READY, oFPA_NUMBERS, oFPA_OPERATION, oEN,
        output oRESULT, oFLAGS, oRESULT_VALID, oTIMEOUT
    );

    modport slave (
        output iS_DATA, iS_VALID, iS_LAST, iS_OPERATION,
        output iFPA_RESULT, iFPA_FLAGS, iFPA_DATA_VALID,
        input  oS_READY, oFPA_NUMBERS, oFPA_OPERATION, oEN,
        input  oRESULT, oFLAGS, oRESULT_VALID, oTIMEOUT
    );
endinterface

// File: rtl/fpa_arr_loader.sv
// Feeder for the array FP adder: gathers a frame of up to N+1 words, zero-pads it,
// holds it on the adder while enabled, then returns the result/flags or a timeout pulse.
module fpa_arr_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int N              = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             iCLK,
    input  logic             iNRESET,
    fpa_arr_loader_if.master bus
);
    localparam int CW = (N > 0) ? $clog2(N + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(N);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [N:0][DATA_WIDTH-1:0] numbers_q, numbers_d;
    logic [1:0]                 op_q, op_d;
    logic [DATA_WIDTH-1:0]      result_q, result_d;
    logic [2:0]                 flags_q, flags_d;
    logic                       result_valid_q, result_valid_d;
    logic                       timeout_q, timeout_d;
    logic                       ready_q, ready_d;
    logic                       en_q, en_d;

    always_ff @(posedge iCLK) begin
        if (!iNRESET) begin
            state_q        <= S_FILL;
            cnt_q          <= '0;
            timer_q        <= '0;
            numbers_q      <= '0;
            op_q           <= '0;
            result_q       <= '0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            ready_q        <= 1'b0;
            en_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            numbers_q      <= numbers_d;
            op_q           <= op_d;
            result_q       <= result_d;
            flags_q        <= flags_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            ready_q        <= ready_d;
            en_q           <= en_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        numbers_d      = numbers_q;
        op_d           = op_q;
        result_d       = result_q;
        flags_d        = flags_q;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;

        unique case (state_q)
            S_FILL: begin
                // ready_q gates acceptance so the first cycle after reset takes nothing
                if (bus.iS_VALID && ready_q) begin
                    numbers_d[cnt_q] = bus.iS_DATA;
                    if (cnt_q == '0) begin
                        op_d = bus.iS_OPERATION;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (bus.iS_LAST) begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                numbers_d[cnt_q] = '0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (bus.iFPA_DATA_VALID) begin
                    result_d       = bus.iFPA_RESULT;
                    flags_d        = bus.iFPA_FLAGS;
                    result_valid_d = 1'b1;
                    cnt_d          = '0;
                    timer_d        = '0;
                    state_d        = S_FILL;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    timer_d   = '0;
                    state_d   = S_FILL;
                end
            end
            default: begin
                cnt_d   = '0;
                timer_d = '0;
                state_d = S_FILL;
            end
        endcase

        // Handshake and enable are registered from the next state so both drop to 0 in reset
        ready_d = (state_d == S_FILL);
        en_d    = (state_d == S_WAIT);
    end

    assign bus.oS_READY       = ready_q;
    assign bus.oEN            = en_q;
    assign bus.oFPA_NUMBERS   = numbers_q;
    assign bus.oFPA_OPERATION = op_q;
    assign bus.oRESULT        = result_q;
    assign bus.oFLAGS         = flags_q;
    assign bus.oRESULT_VALID  = result_valid_q;
    assign bus.oTIMEOUT       = timeout_q;
endmodule
